// File: rtl/uart_csr_ctrl.sv
// CSR front-end for the UART core: single-outstanding register bus, baud/control
// registers, and a status word with a sticky parity-error flag.
module uart_csr_ctrl #(
  parameter int unsigned           BAUD_W   = 16,
  parameter logic [BAUD_W-1:0]     BAUD_RST = 16'd434,
  parameter int unsigned           DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [BAUD_W-1:0] baud_div,
  output logic              tx_en,
  output logic              rx_en,
  output logic              parity_en,
  output logic              parity_odd,
  input  logic              parity_error,
  input  logic              busy,
  input  logic              free
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam logic [1:0] A_BAUD = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;

  logic [0:0]        state;
  logic [BAUD_W-1:0] shadow;
  logic              pending;
  logic [3:0]        ctrl;
  logic              par_sticky;
  logic              accept;
  logic              baud_wr;
  logic              ctrl_wr;
  logic              par_clr;
  logic              can_apply;
  logic              unmapped;
  logic [DATA_W-1:0] rd_mux;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign unmapped  = (req_addr == 2'd3);
  assign baud_wr   = accept && req_write && (req_addr == A_BAUD);
  assign ctrl_wr   = accept && req_write && (req_addr == A_CTRL);
  assign par_clr   = accept && req_write && (req_addr == A_STAT) && req_wdata[2];
  // The divisor may only move while the UART is idle between frames.
  assign can_apply = !busy && free;

  assign {parity_odd, parity_en, rx_en, tx_en} = ctrl;

  always_comb begin
    rd_mux = '0;
    if (!req_write) begin
      case (req_addr)
        A_BAUD:  rd_mux = DATA_W'(baud_div);
        A_CTRL:  rd_mux = DATA_W'(ctrl);
        A_STAT:  rd_mux = DATA_W'({pending, par_sticky, free, busy});
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      baud_div   <= BAUD_RST;
      shadow     <= BAUD_RST;
      pending    <= 1'b0;
      ctrl       <= 4'h0;
      par_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= RESP;
          rsp_rdata <= rd_mux;
          rsp_err   <= unmapped;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase

      // A fresh BAUD write takes priority over draining an older deferred value.
      if (baud_wr) begin
        if (can_apply) begin
          baud_div <= req_wdata[BAUD_W-1:0];
          pending  <= 1'b0;
        end else begin
          shadow   <= req_wdata[BAUD_W-1:0];
          pending  <= 1'b1;
        end
      end else if (pending && can_apply) begin
        baud_div <= shadow;
        pending  <= 1'b0;
      end

      if (ctrl_wr) ctrl <= req_wdata[3:0];

      // A new error in the same cycle as a clear wins, so no event is lost.
      par_sticky <= parity_error || (par_sticky && !par_clr);
    end
  end

endmodule

// File: tb/tb_uart_csr_ctrl.sv
// Randomized + directed bench for uart_csr_ctrl against a register-level reference model.
module tb_uart_csr_ctrl;

  localparam int BAUD_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write;
  logic [1:0]        req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [BAUD_W-1:0] baud_div;
  logic              tx_en, rx_en, parity_en, parity_odd;
  logic              parity_error, busy, free;

  int n_tests = 0;
  int n_fail  = 0;

  uart_csr_ctrl #(.BAUD_W(BAUD_W), .BAUD_RST(16'd434), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .baud_div(baud_div), .tx_en(tx_en), .rx_en(rx_en),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .parity_error(parity_error), .busy(busy), .free(free)
  );

  always #5 clk = ~clk;

  // Reference model: the register file as the software-visible map describes it.
  int unsigned m_reg [0:2];   // 0 = active baud, 1 = control nibble, 2 = sticky parity flag
  int unsigned m_shadow;
  bit          m_pend;
  bit          m_inresp;
  int unsigned m_rdata;
  bit          m_err;
  bit          m_acc;

  assign m_acc = !m_inresp && req_valid;

  function automatic int unsigned status_word();
    return (int'(busy)) | (int'(free) << 1) | (m_reg[2] << 2) | (int'(m_pend) << 3);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_reg[0] <= 434; m_reg[1] <= 0; m_reg[2] <= 0;
      m_shadow <= 434; m_pend <= 0; m_inresp <= 0; m_rdata <= 0; m_err <= 0;
    end else begin
      if (m_acc) begin
        m_inresp <= 1;
        m_err    <= (req_addr == 3);
        if (req_write || req_addr == 3) m_rdata <= 0;
        else if (req_addr == 2)         m_rdata <= status_word();
        else                            m_rdata <= m_reg[req_addr];
      end else if (m_inresp && rsp_ready) begin
        m_inresp <= 0;
      end
      if (m_acc && req_write && req_addr == 0) begin
        if (!busy && free) begin m_reg[0] <= req_wdata % 65536; m_pend <= 0; end
        else               begin m_shadow <= req_wdata % 65536; m_pend <= 1; end
      end else if (m_pend && !busy && free) begin
        m_reg[0] <= m_shadow; m_pend <= 0;
      end
      if (m_acc && req_write && req_addr == 1) m_reg[1] <= req_wdata % 16;
      if (parity_error) m_reg[2] <= 1;
      else if (m_acc && req_write && req_addr == 2 && req_wdata[2]) m_reg[2] <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("req_ready", 32'(req_ready), 32'(!m_inresp));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_inresp));
    if (m_inresp) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    chk("baud_div", 32'(baud_div), m_reg[0]);
    chk("ctrl", 32'({parity_odd, parity_en, rx_en, tx_en}), m_reg[1]);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  logic [31:0] last_rdata;
  logic        last_err;

  // One full access from idle: accept, then complete the handshake.
  task automatic acc(input logic w, input logic [1:0] a, input logic [31:0] d);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 0;
    step();
    last_rdata = rsp_rdata; last_err = rsp_err;
    req_valid = 0; rsp_ready = 1;
    step();
    rsp_ready = 0;
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; parity_error = 0; busy = 0; free = 1;
    step(); step();
    chk("rst_baud", 32'(baud_div), 32'd434);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1;
    step();

    acc(0, 0, 0); chk("rd_baud_rst", last_rdata, 32'd434); chk("rd_err0", 32'(last_err), 0);
    acc(0, 1, 0); chk("rd_ctrl_rst", last_rdata, 32'd0);
    acc(0, 2, 0); chk("rd_stat_rst", last_rdata, 32'h2);

    acc(1, 0, 32'h0000_0057); chk("baud_now", 32'(baud_div), 32'h57);
    acc(0, 0, 0); chk("rd_baud_57", last_rdata, 32'h57);

    busy = 1; free = 0;
    acc(1, 0, 32'h1A0); acc(1, 0, 32'h1B0);
    chk("baud_deferred", 32'(baud_div), 32'h57);
    acc(0, 2, 0); chk("stat_pending", last_rdata, 32'h9);
    busy = 0; free = 1;
    step(); chk("baud_applied", 32'(baud_div), 32'h1B0);
    acc(0, 2, 0); chk("stat_pend_clr", last_rdata, 32'h2);

    parity_error = 1; step(); parity_error = 0; step();
    acc(0, 2, 0); chk("par_set", last_rdata, 32'h6);
    parity_error = 1; acc(1, 2, 32'h4); parity_error = 0;
    acc(0, 2, 0); chk("par_set_wins", last_rdata, 32'h6);
    acc(1, 2, 32'h4);
    acc(0, 2, 0); chk("par_clr", last_rdata, 32'h2);

    acc(1, 1, 32'hFF); chk("ctrl_bits", 32'({parity_odd, parity_en, rx_en, tx_en}), 32'hF);
    acc(0, 1, 0); chk("rd_ctrl_f", last_rdata, 32'hF);
    acc(1, 3, 32'h1234); chk("unmap_err", 32'(last_err), 1); chk("unmap_rd", last_rdata, 0);
    acc(0, 3, 0); chk("unmap_rd_err", 32'(last_err), 1);

    // Stall the response and try to sneak in a request that would clear CONTROL_0.
    req_valid = 1; req_write = 0; req_addr = 0; req_wdata = 0;
    step();
    req_write = 1; req_addr = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rdata", rsp_rdata, 32'h1B0);
    end
    rst_n = 0; req_valid = 0;
    step();
    chk("rst_mid_valid", 32'(rsp_valid), 0);
    chk("rst_mid_baud", 32'(baud_div), 32'd434);
    rst_n = 1;
    step();

    for (int i = 0; i < 3000; i++) begin
      req_valid    = ($urandom_range(0, 2) != 0);
      req_write    = $urandom_range(0, 1);
      req_addr     = 2'($urandom_range(0, 3));
      req_wdata    = $urandom;
      rsp_ready    = ($urandom_range(0, 2) != 0);
      parity_error = ($urandom_range(0, 7) == 0);
      busy         = $urandom_range(0, 1);
      free         = $urandom_range(0, 1);
      rst_n        = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
